// File: rtl/dircc_mem_arb_pkg.sv
// Shared definitions for the processing-memory port arbiter and its helpers.
package dircc_mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;
  localparam int BE_W_DEF   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Index width for 'value' distinct codes; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dircc_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap.
module dircc_rr_pick
  import dircc_mem_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = |req;
    // Walk from the farthest offset down so the nearest request overwrites.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) winner = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/dircc_processing_mem_port_arbiter.sv
// Round-robin arbiter sharing memory port 2 among on-node requesters, with bounded bursts.
module dircc_processing_mem_port_arbiter
  import dircc_mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BE_W      = BE_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic                      freeze,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_readdata,
  output logic [ADDR_W-1:0]         mem_address2,
  output logic [BE_W-1:0]           mem_byteenable2,
  output logic                      mem_chipselect2,
  output logic                      mem_write2,
  output logic [DATA_W-1:0]         mem_writedata2,
  input  logic [DATA_W-1:0]         mem_readdata2,
  output logic                      busy
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             rsp_pend;
  logic [IDX_W-1:0] rsp_id;

  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             any_req;
  logic             owner_valid;
  logic             issue;
  logic             release_own;

  dircc_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .winner    (pick_idx),
    .any_valid (any_req)
  );

  assign owner_valid = req_valid[owner];
  assign issue       = (state == OWN) & owner_valid & clken & ~freeze;
  // A dropped request releases even while stalled; a full burst releases on its last beat.
  assign release_own = (state == OWN) & (~owner_valid | (issue & (beat_cnt == LAST_BEAT)));
  assign next_ptr    = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      rsp_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= pick_idx;
            beat_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (release_own) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (issue) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      rsp_pend <= issue & ~req_write[owner];
    end
  end

  always_ff @(posedge clk) begin
    if (issue) rsp_id <= owner;
  end

  // Issue stage: owner's slice drives the memory port only while a beat is issued.
  always_comb begin
    req_ready = '0;
    if (issue) req_ready[owner] = 1'b1;
    mem_chipselect2 = issue;
    mem_write2      = issue & req_write[owner];
    mem_address2    = issue ? req_address[int'(owner)*ADDR_W +: ADDR_W]  : '0;
    mem_writedata2  = issue ? req_writedata[int'(owner)*DATA_W +: DATA_W] : '0;
    mem_byteenable2 = issue ? req_byteenable[int'(owner)*BE_W +: BE_W]   : '0;
  end

  // Response stage: memory read latency is one cycle, data passes straight through.
  always_comb begin
    rsp_valid = '0;
    if (rsp_pend) rsp_valid[rsp_id] = 1'b1;
  end

  assign rsp_readdata = mem_readdata2;
  assign busy         = (state == OWN);

endmodule

// File: tb/tb_dircc_processing_mem_port_arbiter.sv
// Bench for the port-2 arbiter: vector table, scoreboarded read responses, corner sequences.
module tb_dircc_processing_mem_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int BW = 2;

  logic            clk;
  logic            reset;
  logic            clken;
  logic            freeze;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_address;
  logic [NR*DW-1:0] req_writedata;
  logic [NR*BW-1:0] req_byteenable;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_readdata;
  logic [AW-1:0]   mem_address2;
  logic [BW-1:0]   mem_byteenable2;
  logic            mem_chipselect2;
  logic            mem_write2;
  logic [DW-1:0]   mem_writedata2;
  logic [DW-1:0]   mem_readdata2;
  logic            busy;

  logic [AW-1:0] addr_r  [NR];
  logic [DW-1:0] wdata_r [NR];
  logic [BW-1:0] be_r    [NR];

  int n_checks = 0;
  int n_fail   = 0;

  dircc_processing_mem_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_BURST(8)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken), .freeze(freeze),
    .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
    .req_writedata(req_writedata), .req_byteenable(req_byteenable),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata),
    .mem_address2(mem_address2), .mem_byteenable2(mem_byteenable2),
    .mem_chipselect2(mem_chipselect2), .mem_write2(mem_write2),
    .mem_writedata2(mem_writedata2), .mem_readdata2(mem_readdata2), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    req_address    = '0;
    req_writedata  = '0;
    req_byteenable = '0;
    for (int i = 0; i < NR; i++) begin
      req_address[i*AW +: AW]    = addr_r[i];
      req_writedata[i*DW +: DW]  = wdata_r[i];
      req_byteenable[i*BW +: BW] = be_r[i];
    end
  end

  // Memory model: registered read, byte-lane writes, output held while clken is low.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit mem_loaded;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 16'(i * 7 + 3);
      mem[14'h0123] <= 16'hBEEF;
      mem[14'h3A97] <= 16'h1234;
      mem_loaded <= 1'b1;
    end else if (clken && mem_chipselect2) begin
      if (mem_write2) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable2[b]) mem[mem_address2][b*8 +: 8] <= mem_writedata2[b*8 +: 8];
      end else begin
        mem_readdata2 <= mem[mem_address2];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } sb_t;
  sb_t sb_q [$];
  bit  pend_chk;

  // Scoreboard: each issued read expects a response on the following cycle.
  always @(negedge clk) begin
    sb_t e;
    logic [1:0] id;
    if (pend_chk && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.id));
      chk("rsp_data", 32'(rsp_readdata), 32'(e.data));
    end else if (mem_loaded && rsp_valid !== 4'b0000) begin
      chk("rsp_spurious", 32'(rsp_valid), 32'h0);
    end
    pend_chk = 1'b0;
    if (mem_chipselect2 === 1'b1 && mem_write2 === 1'b0) begin
      id = 2'd0;
      for (int i = 0; i < NR; i++) if (req_ready[i]) id = 2'(i);
      sb_q.push_back('{id: id, data: mem[mem_address2]});
      pend_chk = 1'b1;
    end
    if (reset) begin
      sb_q.delete();
      pend_chk = 1'b0;
    end
  end

  typedef struct packed {
    logic        rst;
    logic        ce;
    logic        frz;
    logic [3:0]  vld;
    logic [3:0]  exp_rdy;
    logic        exp_cs;
    logic        exp_busy;
    logic [13:0] exp_addr;
    logic [3:0]  exp_rsp;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_write = '0; clken = 1'b1; freeze = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] exp5;
    logic [5:0] exp6;
    reset = 1'b1; clken = 1'b1; freeze = 1'b0; req_valid = '0; req_write = '0;
    addr_r  = '{14'h0040, 14'h0123, 14'h0200, 14'h0333};
    wdata_r = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    be_r    = '{2'b11, 2'b11, 2'b11, 2'b11};

    //          rst   ce    frz   vld      rdy      cs    busy  addr      rsp      rdata
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 14'h0000, 4'b0000, 16'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 14'h0000, 4'b0000, 16'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 14'h0123, 4'b0000, 16'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 14'h0000, 4'b0010, 16'hBEEF};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 14'h0000, 4'b0000, 16'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 14'h0000, 4'b0000, 16'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1, 14'h0000, 4'b0000, 16'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1, 14'h0000, 4'b0000, 16'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 14'h0000, 4'b0000, 16'h0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 14'h0000, 4'b0000, 16'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0, 14'h0000, 4'b0000, 16'h0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'b1010, 4'b0010, 1'b1, 1'b1, 14'h0123, 4'b0000, 16'h0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 14'h0000, 4'b0010, 16'hBEEF};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 14'h0000, 4'b0000, 16'h0};

    step();
    step();

    for (int r = 0; r < 14; r++) begin
      reset = tbl[r].rst; clken = tbl[r].ce; freeze = tbl[r].frz; req_valid = tbl[r].vld;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].exp_rdy));
      chk($sformatf("tbl%0d_cs", r), 32'(mem_chipselect2), 32'(tbl[r].exp_cs));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].exp_busy));
      chk($sformatf("tbl%0d_addr", r), 32'(mem_address2), 32'(tbl[r].exp_addr));
      chk($sformatf("tbl%0d_rspv", r), 32'(rsp_valid), 32'(tbl[r].exp_rsp));
      if (tbl[r].exp_rsp != 4'b0000)
        chk($sformatf("tbl%0d_rdata", r), 32'(rsp_readdata), 32'(tbl[r].exp_rdata));
      step();
    end

    // Four continuous readers: 8 beats each, one arbitration cycle between owners.
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      exp5 = ((c % 9) == 0) ? 5'b0 : {1'b1, 4'b0001 << ((c / 9) % 4)};
      chk($sformatf("rr_c%0d", c), 32'({busy, req_ready}), 32'(exp5));
      step();
    end
    req_valid = '0;
    step();
    step();

    // clken low for three cycles after four beats: stall without losing ownership.
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < 13; c++) begin
      clken = (c >= 5 && c <= 7) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 0 || c == 12)      exp6 = 6'b0;
      else if (c >= 5 && c <= 7)  exp6 = {1'b1, 1'b0, 4'b0000};
      else                        exp6 = {1'b1, 1'b1, 4'b0001};
      chk($sformatf("ce_c%0d", c), 32'({busy, mem_chipselect2, req_ready}), 32'(exp6));
      step();
    end
    req_valid = '0;
    clken = 1'b1;
    step();
    step();

    // Partial byte write by requester 2, then read it back.
    do_reset();
    addr_r[2] = 14'h3A97; wdata_r[2] = 16'hA5A5; be_r[2] = 2'b01;
    req_valid = 4'b0100; req_write = 4'b0100;
    @(negedge clk);
    chk("wr_idle_busy", 32'(busy), 32'h0);
    step();
    @(negedge clk);
    chk("wr_ready", 32'(req_ready), 32'h4);
    chk("wr_write", 32'(mem_write2), 32'h1);
    chk("wr_be", 32'(mem_byteenable2), 32'h1);
    chk("wr_data", 32'(mem_writedata2), 32'hA5A5);
    chk("wr_addr", 32'(mem_address2), 32'h3A97);
    step();
    req_write = 4'b0000;
    @(negedge clk);
    chk("rd_ready", 32'(req_ready), 32'h4);
    chk("rd_write", 32'(mem_write2), 32'h0);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("rb_valid", 32'(rsp_valid), 32'h4);
    chk("rb_data", 32'(rsp_readdata), 32'h12A5);
    step();
    step();

    // Reset sampled right after an issued read drops the response.
    do_reset();
    req_valid = 4'b0001;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_issue_cs", 32'(mem_chipselect2), 32'h1);
    step();
    reset = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_cs", 32'(mem_chipselect2), 32'h0);
    chk("rst_write", 32'(mem_write2), 32'h0);
    chk("rst_addr", 32'(mem_address2), 32'h0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
